// File: rtl/serial_to_parallel_rx_if.sv
// Lane receive bus: serial bit in, rebuilt symbol / valid / lane-active out.
interface serial_to_parallel_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  // Serializer / consumer side: drives bits, observes rebuilt symbols
  modport master (output data_in, input data_out, valid_out, active);
  // Receiver side
  modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Per-lane serial-to-parallel receiver. Bit-slides to find COM, needs
// COM_COUNT consecutive aligned COMs to go ACTIVE, then delivers every
// non-COM/non-IDL symbol on data_out with valid_out for one symbol period.
module serial_to_parallel_rx #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] COM     = 8'hBC,
  parameter logic [WIDTH-1:0] IDL     = 8'h7C,
  parameter int             COM_COUNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_to_parallel_rx_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(COM_COUNT + 1);
  localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);
  localparam logic [CW-1:0] COM_MAX = CW'(COM_COUNT);

  typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    com_cnt;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             active_q;

  // Word ending with the bit sampled on this edge
  logic [WIDTH-1:0] cand;
  logic             boundary;
  assign cand     = {shift[WIDTH-2:0], bus.data_in};
  assign boundary = (bit_cnt == LAST);

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;

  // Alignment FSM plus registered symbol outputs; outputs move only at boundaries
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      shift    <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shift <= cand;
      case (state)
        HUNT: begin
          // Sliding search: any bit position may start a symbol
          bit_cnt <= '0;
          if (cand == COM) begin
            com_cnt <= CW'(1);
            if (COM_MAX <= CW'(1)) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
          if (boundary) begin
            if (cand == COM) begin
              if (com_cnt + CW'(1) >= COM_MAX) begin
                com_cnt  <= COM_MAX;
                state    <= ACTIVE;
                active_q <= 1'b1;
              end else begin
                com_cnt <= com_cnt + CW'(1);
              end
            end else begin
              // Any non-COM symbol (IDL included) breaks alignment
              state   <= HUNT;
              com_cnt <= '0;
              bit_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
          if (boundary) begin
            if (cand == COM || cand == IDL) begin
              valid_q <= 1'b0;
            end else begin
              data_q  <= cand;
              valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= HUNT;
          bit_cnt <= '0;
          com_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx: symbol table plus reset sequences.
module tb_serial_to_parallel_rx;
  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  serial_to_parallel_rx_if #(.WIDTH(8)) bus ();

  serial_to_parallel_rx #(
    .WIDTH(8), .COM(8'hBC), .IDL(8'h7C), .COM_COUNT(4)
  ) dut (
    .clk_32f(clk_32f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] sym;
    logic [7:0] exp_d;
    logic       exp_v;
    logic       exp_a;
  } vec_t;

  vec_t tab [0:21];
  int checks = 0;
  int errors = 0;
  logic [7:0] cur_d;
  logic       cur_v;
  logic       cur_a;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"},   bus.data_out,         cur_d);
    chk({tag, ".valid"},  {7'd0, bus.valid_out}, {7'd0, cur_v});
    chk({tag, ".active"}, {7'd0, bus.active},    {7'd0, cur_a});
  endtask

  // Drive one bit, let the posedge sample it, then settle 1 time unit
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Send table rows MSB first; outputs must hold until the LSB edge
  task automatic apply(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(tab[r].sym[i]);
        if (i == 0) begin
          cur_d = tab[r].exp_d;
          cur_v = tab[r].exp_v;
          cur_a = tab[r].exp_a;
          chk_all($sformatf("row%0d", r));
        end else begin
          chk_all($sformatf("row%0d.hold", r));
        end
      end
    end
  endtask

  task automatic clear_exp();
    cur_d = 8'h00;
    cur_v = 1'b0;
    cur_a = 1'b0;
  endtask

  initial begin
    logic [7:0] quiet [0:2];
    logic [7:0] pb;
    // alignment
    tab[0]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[1]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[2]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[3]  = '{8'hBC, 8'h00, 1'b0, 1'b1};
    tab[4]  = '{8'hEE, 8'hEE, 1'b1, 1'b1};
    tab[5]  = '{8'h7C, 8'hEE, 1'b0, 1'b1};
    // broken sync
    tab[6]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[7]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[8]  = '{8'h12, 8'h00, 1'b0, 1'b0};
    tab[9]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[10] = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[11] = '{8'hBC, 8'h00, 1'b0, 1'b0};
    tab[12] = '{8'hBC, 8'h00, 1'b0, 1'b1};
    tab[13] = '{8'hFD, 8'hFD, 1'b1, 1'b1};
    // idle / comma gaps
    tab[14] = '{8'hEF, 8'hEF, 1'b1, 1'b1};
    tab[15] = '{8'h7C, 8'hEF, 1'b0, 1'b1};
    tab[16] = '{8'hBC, 8'hEF, 1'b0, 1'b1};
    tab[17] = '{8'hF0, 8'hF0, 1'b1, 1'b1};
    // incrementing across wrap
    tab[18] = '{8'hFE, 8'hFE, 1'b1, 1'b1};
    tab[19] = '{8'hFF, 8'hFF, 1'b1, 1'b1};
    tab[20] = '{8'h00, 8'h00, 1'b1, 1'b1};
    tab[21] = '{8'h01, 8'h01, 1'b1, 1'b1};

    bus.data_in = 1'b0;
    clear_exp();

    // Held in reset with random bits: outputs stay cleared
    for (int c = 0; c < 20; c++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_all("in_reset");
    end
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      send_bit(1'b0);
      chk_all("zeros_hunt");
    end

    // Three stray bits, then 4xCOM and data
    send_bit(1'b1); chk_all("pre0");
    send_bit(1'b0); chk_all("pre1");
    send_bit(1'b1); chk_all("pre2");
    apply(0, 5);

    // Restart and break sync with a non-COM byte
    reset = 1'b0;
    #2;
    clear_exp();
    chk_all("rst_pulse");
    reset = 1'b1;
    apply(6, 13);
    apply(14, 17);
    apply(18, 21);

    // Reset mid-byte in ACTIVE: clears without a clock edge
    pb = 8'hA5;
    for (int i = 7; i >= 5; i--) begin
      send_bit(pb[i]);
      chk_all("pre_rst_hold");
    end
    bus.data_in = pb[4];
    #2;
    reset = 1'b0;
    #1;
    clear_exp();
    chk_all("async_rst");
    #1;
    reset = 1'b1;
    quiet[0] = 8'h00; quiet[1] = 8'h5A; quiet[2] = 8'h7C;
    for (int k = 0; k < 3; k++) begin
      pb = quiet[k];
      for (int i = 7; i >= 0; i--) begin
        send_bit(pb[i]);
        chk_all("no_realign");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case a stimulus step stalls
  initial begin
    #200000;
    $display("FAIL timeout: got stalled want finished");
    $fatal(1);
  end
endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side lane stage of the PHY. Consumes the serial bit stream from the lane serializer, clocked at clk_32f, MSB first.
- Finds byte alignment from COM (8'hBC) symbols and declares the lane active after COM_COUNT consecutive aligned COMs.
- Rebuilds 8-bit data with a valid flag for the lane demux / clk_f domain logic.
- One instance per lane.

Parameters:
- WIDTH, 8: symbol width in bits.
- COM, 8'hBC: alignment/comma symbol.
- IDL, 8'h7C: idle symbol sent when the transmitter has no valid data.
- COM_COUNT, 4: consecutive aligned COMs required before ACTIVE.

Ports:
- clk_32f  input  1: bit clock. All logic on its posedge.
- reset  input  1: asynchronous, active-low. 0 = reset.
- data_in  input  1: serial bit, MSB of each symbol first.
- data_out  output  WIDTH: last received data symbol. Held between updates.
- valid_out  output  1: data_out holds a data symbol (not COM/IDL). Held for a full symbol period.
- active  output  1: lane aligned and in ACTIVE.

Behaviour:
- Reset (async, reset==0): state=HUNT, shift=0, bit_cnt=0, com_cnt=0, data_out=8'h00, valid_out=0, active=0. Reset asserted mid-operation clears everything immediately. After release, alignment restarts from HUNT.
- Shifting, every posedge: shift <= {shift[WIDTH-2:0], data_in}.
- Candidate word: cand = {shift[WIDTH-2:0], data_in}, i.e. the WIDTH bits ending with the bit sampled this edge.
- HUNT:
  - Compare cand to COM every cycle (bit-sliding search).
  - On match: state=SYNC, com_cnt=1, bit_cnt=0. This edge is a symbol boundary.
  - Outputs unchanged (valid_out=0, active=0).
- SYNC:
  - bit_cnt increments 0..7 and wraps. A symbol boundary is the edge where bit_cnt==WIDTH-1; cand is evaluated only there.
  - cand==COM: com_cnt+1. If the new count equals COM_COUNT, state=ACTIVE, active=1 on that same edge.
  - cand!=COM: state=HUNT, com_cnt=0, bit_cnt=0. A non-COM byte never counts toward alignment.
- ACTIVE:
  - bit_cnt keeps wrapping. At each symbol boundary:
    - cand==COM or cand==IDL: valid_out=0; data_out holds its previous value.
    - Otherwise: data_out=cand, valid_out=1.
  - Outputs change only at boundaries, so each is stable for exactly WIDTH clk_32f cycles.
  - ACTIVE is left only through reset. Loss-of-sync detection is out of scope for this block.
- Latency: data_out/valid_out update on the same posedge that samples the symbol's last bit (LSB). They are registered outputs and visible after that edge.
- Boundary conditions:
  - A COM pattern straddling two symbols in SYNC/ACTIVE is ignored (checked only at boundaries).
  - IDL in SYNC breaks alignment (back to HUNT).
  - com_cnt saturates at COM_COUNT.
  - bit_cnt wrap from 7 to 0 has no idle cycle.
  - A byte equal to COM/IDL cannot be delivered as data (reserved symbols).

Test Plan:
- Reset check: reset=0 with random data_in for 20 cycles -> data_out=8'h00, valid_out=0, active=0 throughout. Deassert, then feed 8'h00 bits -> stays HUNT, active=0.
- Alignment: 3 arbitrary bits, then 4×8'hBC, then 8'hEE -> active rises on the edge sampling the LSB of the 4th BC. data_out=8'hEE, valid_out=1 on the edge sampling EE's LSB. Both held 8 cycles.
- Broken sync: BC, BC, 8'h12, BC×4, 8'hFD -> no active after the first two BCs (back to HUNT on 8'h12). Active after the next 4 BCs. Then data_out=8'hFD, valid_out=1.
- Idle/COM gaps in ACTIVE: after alignment send 8'hEF, 8'h7C, 8'hBC, 8'hF0 -> valid_out 1,0,0,1. data_out EF,EF,EF,F0.
- Incrementing stream: after alignment send 8'hFE, 8'hFF, 8'h00, 8'h01 -> data_out follows each value at 8-cycle spacing, valid_out=1 continuously.
- Reset mid-stream: assert reset during the 4th bit of a data byte in ACTIVE -> outputs clear immediately (no clock). After release with no new COMs -> active stays 0.
